// File: rtl/sram_ctrl_if.sv
// Request/ready handshake between the MEM stage (master) and the SRAM controller (slave).
interface sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output rd_en, output wr_en, output addr, output wdata,
                  input rdata, input ready);
  modport slave  (input rd_en, input wr_en, input addr, input wdata,
                  output rdata, output ready);
endinterface

// File: rtl/sram_ctrl.sv
// 32-bit word access to a 16-bit async SRAM as two wait-stated halfword accesses,
// low half first; ready stays low while an access is in flight.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HOLD = CW'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_wr;
    logic [16:0]   word;
    logic [16:0]   word_next;
    logic [15:0]   wdata_hi;
    logic [15:0]   dq_out;
    logic          dq_oe;
    logic [31:0]   rdata_q;

    assign word_next = 17'((bus.addr - BASE_ADDR) >> 2);

    // Outputs are registered, so each phase's address/strobe/data are set on the edge entering it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            word      <= '0;
            wdata_hi  <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            rdata_q   <= '0;
            sram_we_n <= 1'b1;
            sram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        op_wr     <= bus.wr_en;
                        word      <= word_next;
                        wdata_hi  <= bus.wdata[31:16];
                        dq_out    <= bus.wdata[15:0];
                        dq_oe     <= bus.wr_en;
                        sram_we_n <= ~bus.wr_en;
                        sram_addr <= {word_next, 1'b0};
                        cnt       <= '0;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= HI;
                        sram_addr <= {word, 1'b1};
                        dq_out    <= wdata_hi;
                        sram_we_n <= ~op_wr;
                        if (!op_wr) rdata_q[15:0] <= sram_dq;
                    end else begin
                        cnt <= cnt + CW'(1);
                        // release the strobe one cycle early so data is held past we_n rising
                        if (cnt == CNT_HOLD) sram_we_n <= 1'b1;
                    end
                end
                HI: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        sram_addr <= '0;
                        dq_oe     <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (!op_wr) rdata_q[31:16] <= sram_dq;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_HOLD) sram_we_n <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = rst | ((state == IDLE) & ~bus.rd_en & ~bus.wr_en) | (state == DONE);
    assign bus.rdata = rdata_q;
    assign sram_dq   = dq_oe ? dq_out : 'z;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
